// File: rtl/fifo_ctrl.sv
// FIFO controller for an 8 x 32 register file: owns head/tail/count,
// drives the register file write/read controls, registers popped data
// and reports per-request ack/error status one cycle after the request.
module fifo_ctrl #(
   parameter int DW = 32,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic          rd_en,
   input  logic [DW-1:0] rData,
   output logic [AW-1:0] wAddr,
   output logic          we,
   output logic [AW-1:0] rAddr,
   output logic [DW-1:0] d_out,
   output logic [AW:0]   data_count,
   output logic          full,
   output logic          empty,
   output logic          wr_ack,
   output logic          wr_err,
   output logic          rd_ack,
   output logic          rd_err
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   typedef enum logic [2:0] {
      S_INIT, S_NO_OP, S_WRITE, S_READ, S_WR_RD, S_WR_ERROR, S_RD_ERROR
   } state_t;

   state_t        r_state, w_next;
   logic          r_mix, w_mix;
   logic [AW-1:0] r_head, r_tail;
   logic [AW:0]   r_count;
   logic [DW-1:0] r_dout;
   logic          w_full, w_empty, w_wr_ok, w_rd_ok;

   assign w_full  = (r_count == DEPTH);
   assign w_empty = (r_count == '0);
   // Reset suppresses both requests so a reset cycle never writes the
   // register file or moves a pointer.
   assign w_wr_ok = wr_en & ~w_full  & ~reset_n;
   assign w_rd_ok = rd_en & ~w_empty & ~reset_n;

   assign wAddr      = r_tail;
   assign rAddr      = r_head;
   assign we         = w_wr_ok;
   assign d_out      = r_dout;
   assign data_count = r_count;
   assign full       = w_full;
   assign empty      = w_empty;

   // Pointer, occupancy and read-data datapath.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_dout  <= '0;
      end else begin
         if (w_wr_ok) r_tail <= r_tail + 1'b1;
         if (w_rd_ok) begin
            r_head <= r_head + 1'b1;
            r_dout <= rData;
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // State register; r_mix marks a one-sided rejection alongside an accepted op.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_state <= S_INIT;
         r_mix   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_mix   <= w_mix;
      end
   end

   // Next state from this cycle's requests.
   always_comb begin
      w_next = S_NO_OP;
      w_mix  = (w_wr_ok & rd_en & ~w_rd_ok) | (w_rd_ok & wr_en & ~w_wr_ok);
      if (w_wr_ok && w_rd_ok) w_next = S_WR_RD;
      else if (w_wr_ok)       w_next = S_WRITE;
      else if (w_rd_ok)       w_next = S_READ;
      else if (wr_en)         w_next = S_WR_ERROR;
      else if (rd_en)         w_next = S_RD_ERROR;
   end

   // Status flags decoded from the state of the previous request.
   always_comb begin
      wr_ack = (r_state == S_WRITE) || (r_state == S_WR_RD);
      rd_ack = (r_state == S_READ)  || (r_state == S_WR_RD);
      wr_err = (r_state == S_WR_ERROR) || ((r_state == S_READ)  && r_mix);
      rd_err = (r_state == S_RD_ERROR) || ((r_state == S_WRITE) && r_mix);
   end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Control and read-data stage for the 8-entry x 32-bit register file used as FIFO storage. It owns the head pointer, tail pointer and occupancy count. It turns wr_en/rd_en requests into the register file's wAddr/we/rAddr controls. It registers the read word from rData onto d_out and reports full/empty plus per-cycle ack/error status.

Parameters:
DW, 32, data width; must equal register file width.
AW, 3, address width; DEPTH = 2**AW = 8 entries.

Ports:
clk  input  1  rising-edge clock, single domain
reset_n  input  1  synchronous reset, active-high (1 = reset), sampled on clk rising edge
wr_en  input  1  push request this cycle
rd_en  input  1  pop request this cycle
rData  input  DW  combinational read data from register file at rAddr
wAddr  output  AW  register file write address (= tail)
we  output  1  register file write enable
rAddr  output  AW  register file read address (= head)
d_out  output  DW  registered popped word
data_count  output  AW+1  occupancy, 0..8
full  output  1  data_count == 8
empty  output  1  data_count == 0
wr_ack  output  1  push accepted last cycle
wr_err  output  1  push rejected (full) last cycle
rd_ack  output  1  pop accepted last cycle
rd_err  output  1  pop rejected (empty) last cycle

Behaviour:
- Reset (reset_n=1 at clk edge): head=0, tail=0, data_count=0, d_out=0, all ack/err=0, state=INIT. Resulting outputs: empty=1, full=0. Reset overrides any concurrent wr_en/rd_en; the register file contents are not cleared.
- Combinational outputs: wAddr=tail, rAddr=head, full and empty decoded from data_count.
- Combinational write enable: we = wr_en & accept_wr. This is the only path that writes the register file.
- wr_ok = wr_en & ~full; rd_ok = rd_en & ~empty.
- Simultaneous request on full: accept_wr = wr_ok | (wr_en & rd_en & full) is NOT used. A write on full is always rejected even if a read happens in the same cycle, so accept_wr = wr_ok.
- Push (accept_wr): the register file captures rData-independent wData at tail on the edge; tail <= tail+1 mod 8, wrapping 7->0.
- Pop (rd_ok): d_out <= rData (entry at head) on the edge; head <= head+1 mod 8, wrapping. Read latency is 1 cycle from the rd_en edge to d_out. d_out holds its value when no pop occurs.
- data_count update: +1 if push only, -1 if pop only, unchanged if both or neither.
- Both requests while 0<count<8: push and pop in the same cycle; the popped word is the old head, never the word being written.
- Both requests while empty: push accepted, pop rejected (rd_err). The just-written word is not bypassed to d_out.
- Both requests while full: pop accepted, push rejected (wr_err).
- Status flags (wr_ack, wr_err, rd_ack, rd_err) are registered and valid for exactly the cycle after the request. wr_ack/rd_ack = the accepted condition. wr_err = wr_en & full. rd_err = rd_en & empty.
- State register, next state from the request in the current cycle:
  - INIT: only after reset.
  - NO_OP: no requests.
  - WRITE: push only.
  - READ: pop only.
  - WR_RD: both accepted.
  - WR_ERROR: wr_en rejected and no pop.
  - RD_ERROR: rd_en rejected and no push.
  - Mixed cases: full+both -> READ (wr_err flag set); empty+both -> WRITE (rd_err flag set).
  - The state is internal only; it drives the status flags.
- Invariant: (tail - head) mod 8 == data_count mod 8. data_count never exceeds 8 and never underflows.

Test Plan:
1. Reset, then idle 3 cycles -> empty=1, full=0, data_count=0, d_out=0, we=0, all ack/err=0.
2. Push 0x11111111..0x88888888 on 8 consecutive cycles -> wr_ack=1 each following cycle, wAddr 0..7, full=1 after the 8th. A 9th push gives we=0, wr_err=1, data_count stays 8.
3. From full, pop 8 times -> d_out = 0x11111111..0x88888888 in order, each one cycle after rd_en, empty=1 at end. A 9th pop gives rd_err=1 and d_out holds 0x88888888.
4. Wrap-around: push 5, pop 5, push 6 -> wAddr sequence 5,6,7,0,1,2. Popping returns the 6 words in order with rAddr 5,6,7,0,1,2.
5. Simultaneous: with count=3, assert wr_en=rd_en for 4 cycles -> count stays 3, rd_ack=wr_ack=1 each cycle. On empty, both asserted -> wr_ack=1, rd_err=1, count=1. On full, both asserted -> rd_ack=1, wr_err=1, count=7.
6. Assert reset_n mid-stream with count=5 and wr_en=1 -> next cycle count=0, head=tail=0, empty=1, no ack, d_out=0.
